// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared bus widths, responder FSM states and byte-lane merge helper
package soc_bus_pkg;
    localparam int BUS_W = 32;
    localparam int BE_W  = 4;

    typedef enum logic {IDLE, WAIT} obi_resp_state_e;

    function automatic logic [BUS_W-1:0] be_merge(input logic [BUS_W-1:0] old_word,
                                                  input logic [BUS_W-1:0] new_word,
                                                  input logic [BE_W-1:0] be);
        logic [BUS_W-1:0] r;
        for (int i = 0; i < BE_W; i++)
            r[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/sp_ram_be.sv
// sp_ram_be: single-port byte-enable RAM; a write returns the merged word on rdata
module sp_ram_be
    import soc_bus_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [BE_W-1:0]          be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [BUS_W-1:0]         wdata,
    output logic [BUS_W-1:0]         rdata
);
    logic [BUS_W-1:0] mem [DEPTH];
    logic [BUS_W-1:0] merged;

    assign merged = be_merge(mem[addr], wdata, be);

    // Write-first access so the responder can see the post-store word value
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= merged;
            rdata <= we ? merged : mem[addr];
        end
    end
endmodule

// File: rtl/obi_data_responder.sv
// obi_data_responder: OBI data-bus responder with wait states, RAM, done flag and result shadow
module obi_data_responder
    import soc_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0,
    parameter int FLAG_WORD   = 0,
    parameter int RESULT_WORD = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_req_i,
    output logic             data_gnt_o,
    input  logic [BUS_W-1:0] data_addr_i,
    input  logic             data_we_i,
    input  logic [BE_W-1:0]  data_be_i,
    input  logic [BUS_W-1:0] data_wdata_i,
    output logic             data_rvalid_o,
    output logic [BUS_W-1:0] data_rdata_o,
    output logic             data_err_o,
    output logic             done_o,
    output logic [BUS_W-1:0] result_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    obi_resp_state_e state, state_n;
    logic [2:0]       cnt, cnt_n;
    logic             gnt, oor, en, ld_q, flag_q, done_q;
    logic [AW-1:0]    idx;
    logic [BUS_W-1:0] ram_rdata;

    assign idx        = data_addr_i[AW+1:2];
    assign oor        = data_addr_i >= BUS_W'(4 * DEPTH_WORDS);
    assign data_gnt_o = gnt & ~rst_i;
    assign en         = data_gnt_o & ~oor;

    // Wait-state sequencing: grant at once, or after WAIT_CYCLES held cycles
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt     = 1'b0;
        if (state == IDLE) begin
            if (data_req_i && WAIT_CYCLES == 0) begin
                gnt = 1'b1;
            end else if (data_req_i) begin
                state_n = WAIT;
                cnt_n   = 3'(WAIT_CYCLES);
            end
        end else if (!data_req_i) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            cnt_n   = cnt - 3'd1;
            gnt     = cnt == 3'd1;
            state_n = (cnt == 3'd1) ? IDLE : WAIT;
        end
    end

    // FSM state and wait counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Response register, sticky done flag and result shadow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_rvalid_o <= 1'b0;
            data_err_o    <= 1'b0;
            ld_q          <= 1'b0;
            flag_q        <= 1'b0;
            done_q        <= 1'b0;
            result_o      <= '0;
        end else begin
            data_rvalid_o <= data_gnt_o;
            data_err_o    <= data_gnt_o & oor;
            ld_q          <= en & ~data_we_i;
            flag_q        <= en & data_we_i & (idx == AW'(FLAG_WORD));
            done_q        <= done_o;
            if (en && data_we_i && idx == AW'(RESULT_WORD))
                result_o <= be_merge(result_o, data_wdata_i, data_be_i);
        end
    end

    // The RAM echoes the merged word after a store, so the flag test sees untouched lanes too
    assign data_rdata_o = ld_q ? ram_rdata : '0;
    assign done_o       = done_q | (flag_q & |ram_rdata);

    sp_ram_be #(.DEPTH(DEPTH_WORDS)) u_ram (
        .clk   (clk_i),
        .en    (en),
        .we    (en & data_we_i),
        .be    (data_be_i),
        .addr  (idx),
        .wdata (data_wdata_i),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_obi_data_responder.sv
// tb_obi_data_responder: directed and randomized checks of the responder against a word-array model
module tb_obi_data_responder;
    logic clk, rst;
    logic req0, we0, gnt0, rv0, err0, done0;
    logic [3:0] be0;
    logic [31:0] addr0, wd0, rd0, res0;
    logic req3, we3, gnt3, rv3, err3, done3;
    logic [3:0] be3;
    logic [31:0] addr3, wd3, rd3, res3;

    int total = 0, fails = 0;
    logic [31:0] mdl [16];
    logic [31:0] result_exp = 0;
    logic done_exp = 0;

    obi_data_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req0), .data_gnt_o(gnt0), .data_addr_i(addr0),
        .data_we_i(we0), .data_be_i(be0), .data_wdata_i(wd0), .data_rvalid_o(rv0),
        .data_rdata_o(rd0), .data_err_o(err0), .done_o(done0), .result_o(res0));

    obi_data_responder #(.WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req3), .data_gnt_o(gnt3), .data_addr_i(addr3),
        .data_we_i(we3), .data_be_i(be3), .data_wdata_i(wd3), .data_rvalid_o(rv3),
        .data_rdata_o(rd3), .data_err_o(err3), .done_o(done3), .result_o(res3));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] m;
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic mst(input int w, input logic [31:0] wd, input logic [3:0] be);
        mdl[w] = bmerge(mdl[w], wd, be);
        if (w == 1) result_exp = bmerge(result_exp, wd, be);
        if (w == 0 && mdl[0] != 0) done_exp = 1;
    endtask

    task automatic tx0(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        @(negedge clk);
        req0 = 1; we0 = we; addr0 = a; be0 = be; wd0 = wd;
        #1 chk("gnt0_same_cycle", 32'(gnt0), 1);
        @(negedge clk);
        req0 = 0;
        chk("rvalid0", 32'(rv0), 1);
        rd = rd0; er = err0;
    endtask

    task automatic tx3(input logic we, input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        int n;
        @(negedge clk);
        req3 = 1; we3 = we; addr3 = a; be3 = 4'hF; wd3 = wd; n = 1;
        #1;
        while (!gnt3 && n < 20) begin
            @(negedge clk);
            n++;
            #1;
        end
        chk("gnt3_cycle", 32'(n), 4);
        @(negedge clk);
        req3 = 0;
        chk("rvalid3_next", 32'(rv3), 1);
        rd = rd3;
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        logic [31:0] exp4 [4];
        rst = 1; req0 = 1; we0 = 0; addr0 = 0; be0 = 0; wd0 = 0;
        req3 = 0; we3 = 0; addr3 = 0; be3 = 0; wd3 = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt0), 0);
        chk("rst_rvalid", 32'(rv0), 0);
        chk("rst_rdata", rd0, 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_result", res0, 0);
        req0 = 0; rst = 0;

        tx0(1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er); mst(4, 32'hDEADBEEF, 4'hF);
        chk("store_rdata", rd, 0);
        tx0(0, 32'h10, 4'hF, 0, rd, er);
        chk("load_rdata", rd, 32'hDEADBEEF);
        chk("load_err", 32'(er), 0);

        tx0(1, 32'h10, 4'hF, 32'h11223344, rd, er); mst(4, 32'h11223344, 4'hF);
        tx0(1, 32'h10, 4'h5, 32'hAABBCCDD, rd, er); mst(4, 32'hAABBCCDD, 4'h5);
        tx0(0, 32'h12, 4'h0, 0, rd, er);
        chk("byte_enable", rd, 32'h11BB33DD);

        for (int i = 0; i < 4; i++) begin
            exp4[i] = $urandom;
            tx0(1, 32'(16 + 4 * i), 4'hF, exp4[i], rd, er); mst(4 + i, exp4[i], 4'hF);
        end
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 32'h10;
        #1 chk("b2b_gnt", 32'(gnt0), 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("b2b_rvalid", 32'(rv0), 1);
            chk("b2b_rdata", rd0, exp4[i-1]);
            if (i < 4) begin
                addr0 = 32'(16 + 4 * i);
                #1 chk("b2b_gnt", 32'(gnt0), 1);
            end else req0 = 0;
        end

        tx0(1, 32'h0, 4'hF, 32'h0, rd, er); mst(0, 0, 4'hF);
        tx0(1, 32'h1000, 4'hF, 32'hCAFEF00D, rd, er);
        chk("oor_store_err", 32'(er), 1);
        tx0(0, 32'h1000, 4'hF, 0, rd, er);
        chk("oor_load_err", 32'(er), 1);
        chk("oor_load_rdata", rd, 0);
        chk("oor_no_flag", 32'(done0), 0);
        tx0(0, 32'h0, 4'hF, 0, rd, er);
        chk("oor_word0_kept", rd, 0);

        tx3(1, 32'h8, 32'h12345678, rd);
        @(negedge clk);
        req3 = 1; we3 = 1; addr3 = 32'h8; wd3 = 32'h5555;
        #1 chk("drop_gnt_c1", 32'(gnt3), 0);
        @(negedge clk);
        #1 chk("drop_gnt_c2", 32'(gnt3), 0);
        @(negedge clk);
        req3 = 0;
        #1 chk("drop_gnt_c3", 32'(gnt3), 0);
        @(negedge clk);
        chk("drop_rvalid", 32'(rv3), 0);
        tx3(0, 32'h8, 0, rd);
        chk("drop_no_write", rd, 32'h12345678);

        tx0(1, 32'h4, 4'hF, 32'h37, rd, er); mst(1, 32'h37, 4'hF);
        chk("result_37", res0, 32'h37);
        tx0(1, 32'h0, 4'hF, 32'h1, rd, er); mst(0, 1, 4'hF);
        chk("done_set", 32'(done0), 1);
        tx0(1, 32'h0, 4'hF, 32'h0, rd, er); mst(0, 0, 4'hF);
        chk("done_sticky", 32'(done0), 1);
        @(negedge clk);
        rst = 1; req0 = 1; we0 = 1; addr0 = 32'h4; be0 = 4'hF; wd0 = 32'hFFFFFFFF;
        #1 chk("rst_mid_gnt", 32'(gnt0), 0);
        @(negedge clk);
        chk("rst_mid_done", 32'(done0), 0);
        chk("rst_mid_result", res0, 0);
        chk("rst_mid_rvalid", 32'(rv0), 0);
        rst = 0; req0 = 0; done_exp = 0; result_exp = 0;
        tx0(0, 32'h4, 4'hF, 0, rd, er);
        chk("rst_store_dropped", rd, 32'h37);

        for (int w = 0; w < 16; w++) begin
            logic [31:0] d;
            d = $urandom;
            tx0(1, 32'(4 * w), 4'hF, d, rd, er); mst(w, d, 4'hF);
        end
        for (int k = 0; k < 60; k++) begin
            logic oor, we;
            logic [3:0] be;
            logic [31:0] a, d;
            int w;
            oor = $urandom_range(0, 7) == 0;
            we = $urandom_range(0, 1) == 1;
            be = 4'($urandom_range(0, 15));
            d = $urandom;
            w = $urandom_range(0, 15);
            a = oor ? (32'h1000 | ($urandom & 32'h7FFFFFFF)) : (32'(4 * w) | 32'($urandom_range(0, 3)));
            tx0(we, a, be, d, rd, er);
            chk("rnd_err", 32'(er), 32'(oor));
            chk("rnd_rdata", rd, (!we && !oor) ? mdl[w] : 32'h0);
            if (we && !oor) mst(w, d, be);
            chk("rnd_done", 32'(done0), 32'(done_exp));
            chk("rnd_result", res0, result_exp);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
